// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit.
package hazard_pkg;

    // Widest register address the tag pipeline can hold; narrower addresses
    // are zero-extended into the entry so one struct serves every AW <= 16.
    localparam int ADDR_MAX = 16;

    // Select value meaning "read the register file, no bypass".
    localparam int FWD_SEL_RF = 0;

    // One tracked in-flight instruction.
    typedef struct packed {
        logic                valid;
        logic                wr;
        logic                load;
        logic [ADDR_MAX-1:0] addr;
    } stage_t;

    // Select width: must encode 0 (register file) plus stages 1..n.
    function automatic int sel_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-port priority matcher: finds the youngest in-flight writer of the
// source register and flags it when its load data is not yet available.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int AW         = 4,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SELW       = sel_width(FWD_STAGES)
) (
    input  logic [AW-1:0]                 src_addr_i,
    input  logic                          src_rd_i,
    input  stage_t [FWD_STAGES-1:0]       stages_i,
    output logic [SELW-1:0]               sel_o,
    output logic                          blocked_o
);

    // Scan oldest to youngest so the youngest match overwrites older ones;
    // blocked_o is overwritten together with sel_o, so only the youngest
    // match decides whether the port has to wait for load data.
    always_comb begin
        sel_o     = SELW'(FWD_SEL_RF);
        blocked_o = 1'b0;
        if (src_rd_i) begin
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (stages_i[k-1].valid && stages_i[k-1].wr &&
                    (stages_i[k-1].addr == ADDR_MAX'(src_addr_i))) begin
                    sel_o     = SELW'(k);
                    blocked_o = stages_i[k-1].load && (k <= LOAD_LAT);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks destination tags of in-flight instructions,
// produces per-port bypass selects and a freeze for load-use hazards.
//
// Handshake: there is no valid/ready pair here. issue_valid qualifies the
// issue_* fields for one cycle and is only accepted when freeze=0; while
// freeze=1 the issue fields are ignored and a bubble enters stage 1.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int AW         = 4,
    parameter  int FWD_STAGES = 3,
    parameter  int LOAD_LAT   = 1,
    localparam int SELW       = sel_width(FWD_STAGES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    input  logic                    issue_wr,
    input  logic                    issue_load,
    input  logic [NUM_SRC*AW-1:0]   src_addr,
    input  logic [NUM_SRC-1:0]      src_rd,
    input  logic                    flush,
    input  logic                    stat_clr,
    output logic [NUM_SRC*SELW-1:0] fwd_sel,
    output logic                    freeze,
    output logic [15:0]             stall_cnt
);

    stage_t [FWD_STAGES-1:0] stage_q, stage_d;
    logic   [NUM_SRC-1:0]    blocked;
    logic   [15:0]           stall_cnt_q, stall_cnt_d;

    // Every read port gets its own matcher over the same tag pipeline.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_port
        hazard_match #(
            .AW        (AW),
            .FWD_STAGES(FWD_STAGES),
            .LOAD_LAT  (LOAD_LAT),
            .SELW      (SELW)
        ) u_match (
            .src_addr_i(src_addr[gi*AW +: AW]),
            .src_rd_i  (src_rd[gi]),
            .stages_i  (stage_q),
            .sel_o     (fwd_sel[gi*SELW +: SELW]),
            .blocked_o (blocked[gi])
        );
    end

    assign freeze    = |blocked;
    assign stall_cnt = stall_cnt_q;

    // Tag pipeline next state: flush wins, otherwise shift and insert the
    // issuing instruction, or a bubble while frozen.
    always_comb begin
        stage_d = '0;
        if (!flush) begin
            if (!freeze) begin
                stage_d[0].valid = issue_valid;
                stage_d[0].wr    = issue_wr;
                stage_d[0].load  = issue_load;
                stage_d[0].addr  = ADDR_MAX'(issue_rd);
            end
            for (int k = 1; k < FWD_STAGES; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    // Freeze-cycle counter: clear beats increment, saturates at all ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (freeze && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers; async reset empties the pipeline so freeze drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            stage_q     <= stage_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 4, number of source-operand read ports checked each cycle.
REQ-002 Parameter AW, default 4, register-address width.
REQ-003 Parameter FWD_STAGES, default 3, number of tracked in-flight pipeline stages (EX, MEM, WB); range 1..7.
REQ-004 Parameter LOAD_LAT, default 1, number of stages after EX before load data becomes forwardable; range 0..FWD_STAGES-1.
REQ-005 Derived constant SELW = clog2(FWD_STAGES+1), the mux-select width.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 issue_valid  input  1  an instruction enters EX this cycle.
REQ-009 issue_rd  input  AW  destination register of the issuing instruction.
REQ-010 issue_wr  input  1  the issuing instruction writes issue_rd.
REQ-011 issue_load  input  1  the issuing instruction is a load.
REQ-012 src_addr  input  NUM_SRC*AW  source addresses of the decoding instruction; port i occupies bits [i*AW +: AW].
REQ-013 src_rd  input  NUM_SRC  per-port read enable.
REQ-014 flush  input  1  synchronous invalidation of all tracked stages.
REQ-015 stat_clr  input  1  synchronous clear of stall_cnt.
REQ-016 fwd_sel  output  NUM_SRC*SELW  per-port select: 0 = register file, k = stage k (1 = youngest).
REQ-017 freeze  output  1  stalls fetch/decode and injects a bubble.
REQ-018 stall_cnt  output  16  saturating count of freeze cycles.

Function
REQ-019 The block SHALL hold a FWD_STAGES-deep tag pipeline; each entry holds {valid, wr, load, addr}.
REQ-020 Each cycle, entry k SHALL advance to entry k+1, and the oldest entry SHALL be discarded.
REQ-021 With freeze=0, entry 1 SHALL load {issue_valid, issue_wr, issue_load, issue_rd}.
REQ-022 With freeze=1, entry 1 SHALL load an invalid bubble regardless of the issue inputs, while older entries still advance.
REQ-023 Flush SHALL invalidate every entry on the next edge and SHALL take priority over shifting and issue.
REQ-024 For port i with src_rd[i]=1, fwd_sel SHALL equal the smallest k whose entry is valid, has wr=1 and has addr equal to the port's source address.
REQ-025 fwd_sel SHALL be 0 when src_rd[i]=0 or no entry matches; it SHALL be combinational, with zero latency from its inputs and state.
REQ-026 A port SHALL be load-blocked when its selected entry k has load=1 and k <= LOAD_LAT.
REQ-027 freeze SHALL be the OR of load-blocked over all ports and SHALL be combinational.
REQ-028 Only the youngest match SHALL be considered for load-blocking, so an older load shadowed by a younger ALU write SHALL NOT freeze.
REQ-029 When freeze=1, fwd_sel SHALL still report the matched stage.
REQ-030 stall_cnt SHALL increment on each edge where freeze=1, saturate at 0xFFFF, and clear when stat_clr=1; clearing SHALL take priority over incrementing.
REQ-031 A freeze SHALL self-resolve: after the blocking load advances past stage LOAD_LAT, freeze SHALL deassert without external action.

Reset
REQ-032 While rst_n=0, every entry SHALL be invalid and stall_cnt SHALL be 0, hence fwd_sel=0 and freeze=0.
REQ-033 Reset asserted mid-stall SHALL drop freeze immediately, since reset is asynchronous.

Structure
REQ-034 Package hazard_pkg SHALL hold the stage-entry struct typedef, the SELW computation function, and the FWD_SEL_RF=0 constant.
REQ-035 Each port SHALL instantiate sub-module hazard_match, a combinational priority matcher that returns the select value and the load-blocked flag.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Issue wr to r5, then src0=r5 with rd=1 -> fwd_sel0=1 on cycle 2, =2 on cycle 3, =3 on cycle 4, =0 on cycle 5.
- r10 written in stage 3 and stage 1 both, src=r10 -> fwd_sel=1, the youngest.
- LOAD_LAT=1: load to r7, then next src=r7 -> freeze=1 for exactly 1 cycle, then fwd_sel=2, freeze=0, stall_cnt=1.
- src_rd=0 or wr=0 with matching addresses -> fwd_sel=0, freeze=0.
- Freeze active, then flush -> next cycle all fwd_sel=0 and freeze=0.
- Force 65,540 freeze cycles -> stall_cnt=0xFFFF; stat_clr -> 0; rst_n low mid-freeze -> freeze=0 asynchronously.
